// File: rtl/timer_bcd_display.sv
// timer_bcd_display: captures a 16-bit timer count and converts it to five
// BCD digits with a sequential shift-add-3 engine. The most recently completed
// result is shown on a multiplexed 7-segment display with leading-zero blanking.
module timer_bcd_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        t_valid,
    input  logic [15:0] t_out,
    output logic        busy,
    output logic        bcd_valid,
    output logic [19:0] bcd,
    output logic [4:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic [15:0]   bin;
    logic [19:0]   work;
    logic [19:0]   work_adj;
    logic [3:0]    iter;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [4:1]    blank;
    logic [3:0]    dig;
    logic          blank_cur;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Add-3 correction of every BCD nibble that would overflow when doubled
    always_comb begin
        work_adj = work;
        for (int k = 0; k < 5; k++) begin
            if (work[4*k +: 4] >= 4'd5)
                work_adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
        end
    end

    // Conversion FSM: capture, 16 shift iterations, publish result
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            bin       <= '0;
            work      <= '0;
            iter      <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (t_valid) begin
                        bin   <= t_out;
                        work  <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {work, bin} <= {work_adj[18:0], bin, 1'b0};
                    iter        <= iter + 4'd1;
                    if (iter == 4'd15)
                        state <= DONE;
                end
                DONE: begin
                    bcd       <= work;
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scan timer: each digit stays lit for REFRESH_DIV clocks
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Digit k is blank when it and every more significant digit are zero
    assign blank[4] = (bcd[19:16] == 4'd0);
    assign blank[3] = blank[4] && (bcd[15:12] == 4'd0);
    assign blank[2] = blank[3] && (bcd[11:8]  == 4'd0);
    assign blank[1] = blank[2] && (bcd[7:4]   == 4'd0);

    // Select the scanned digit and its blanking flag
    always_comb begin
        dig       = bcd[3:0];
        blank_cur = 1'b0;
        case (idx)
            3'd1: begin dig = bcd[7:4];   blank_cur = blank[1]; end
            3'd2: begin dig = bcd[11:8];  blank_cur = blank[2]; end
            3'd3: begin dig = bcd[15:12]; blank_cur = blank[3]; end
            3'd4: begin dig = bcd[19:16]; blank_cur = blank[4]; end
            default: begin dig = bcd[3:0]; blank_cur = 1'b0; end
        endcase
    end

    assign an  = ~(5'b00001 << idx);
    assign seg = blank_cur ? 7'b1111111 : seg_decode(dig);
    assign dp  = 1'b1;

endmodule

// File: tb/tb_timer_bcd_display.sv
// Randomized scoreboard bench for timer_bcd_display. A decimal-arithmetic
// model predicts each conversion result and its completion edge; a negedge
// monitor pops predictions on bcd_valid and checks the display every cycle.
module tb_timer_bcd_display;

    localparam int RDIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        t_valid = 1'b0;
    logic [15:0] t_out = '0;
    logic        busy, bcd_valid, dp;
    logic [19:0] bcd;
    logic [4:0]  an;
    logic [6:0]  seg;

    timer_bcd_display #(.REFRESH_DIV(RDIV)) dut (
        .clk(clk), .rst(rst), .t_valid(t_valid), .t_out(t_out),
        .busy(busy), .bcd_valid(bcd_valid), .bcd(bcd),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] SEGT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct {
        int val;
        int en;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   n = 0;
    int   rst_edge = 0;
    int   free_at = 0;
    int   mval = 0;
    int   pend_val = 0;
    int   pend_edge = 0;
    bit   pending = 0;
    bit   active = 0;

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
    endtask

    // Reference model: decides captures and completions per edge
    always @(posedge clk) begin
        n++;
        if (!rst) begin
            mval     = 0;
            pending  = 0;
            free_at  = 0;
            rst_edge = n;
            q.delete();
            active   = 1;
        end else begin
            if (pending && n == pend_edge) begin
                mval    = pend_val;
                pending = 0;
            end
            if (n >= free_at && t_valid === 1'b1) begin
                pend_val  = int'(t_out);
                pend_edge = n + 17;
                pending   = 1;
                free_at   = n + 18;
                q.push_back('{val: int'(t_out), en: n + 17});
            end
        end
    end

    // Monitor: scoreboard pops on bcd_valid, display checked every cycle
    always @(negedge clk) begin
        if (active) begin
            int k, ix, pw;
            logic [4:0] exp_an;
            logic [6:0] exp_seg;
            if (bcd_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("valid_unexpected", bcd_valid, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_edge", n, e.en);
                    chk("bcd_pulse", bcd, to_bcd(e.val));
                end
            end else if (q.size() > 0 && q[0].en <= n) begin
                chk("pulse_missing", bcd_valid, 1);
                void'(q.pop_front());
            end
            k  = n - rst_edge;
            ix = (k / RDIV) % 5;
            pw = 1;
            for (int d = 0; d < ix; d++) pw = pw * 10;
            exp_an  = 5'b11111 ^ (5'b00001 << ix);
            if (ix > 0 && mval < pw) exp_seg = 7'b1111111;
            else                     exp_seg = SEGT[(mval / pw) % 10];
            chk("busy", busy, pending);
            chk("bcd", bcd, to_bcd(mval));
            chk("an", an, exp_an);
            chk("seg", seg, exp_seg);
            chk("dp", dp, 1);
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic capture(input logic [15:0] v, input int idle);
        t_valid = 1'b1;
        t_out   = v;
        cyc(1);
        t_valid = 1'b0;
        cyc(idle);
    endtask

    initial begin
        rst = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(2);
        // directed values: typical, max, zero (blanking), two-digit scan
        capture(16'd1234, 25);
        capture(16'd65535, 25);
        capture(16'd0, 30);
        capture(16'd42, 30);
        // held valid with incrementing count: captures 18 edges apart
        t_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            t_out = 16'(1000 + i);
            cyc(1);
        end
        t_valid = 1'b0;
        cyc(20);
        // reset during iteration 8 aborts the conversion
        capture(16'd4321, 8);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(25);
        // randomized traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            t_valid = ($urandom_range(0, 3) == 0);
            t_out   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom);
            rst     = ($urandom_range(0, 399) != 0);
            cyc(1);
        end
        t_valid = 1'b0;
        rst = 1'b1;
        cyc(25);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
